// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register (MEM/WB and similar) with a 2-entry skid buffer,
// registered upstream ready, synchronous flush, bubble-masked control and a stall counter.
module pipe_stage_skid #(
  parameter int DATA_W  = 64,
  parameter int NUM_CH  = 2,
  parameter int DST_W   = 5,
  parameter int CTRL_W  = 4,
  parameter int STALL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [DST_W-1:0]         in_dst,
  input  logic [DST_W-1:0]         in_fp_dst,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [DST_W-1:0]         out_dst,
  output logic [DST_W-1:0]         out_fp_dst,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [1:0]               occupancy,
  output logic [STALL_W-1:0]       stall_cnt
);

  // state | meaning
  // EMPTY | no beat held
  // ONE   | main register holds the head beat
  // TWO   | main holds the head beat, skid holds the next one; upstream stalled
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam int PW = NUM_CH * DATA_W;
  localparam int BW = PW + 2 * DST_W + CTRL_W;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_in, main_q, skid_q;
  logic            in_ready_q;
  logic            main_valid, skid_valid;
  logic            in_fire, out_fire;
  logic            ld_main_in, ld_main_skid, ld_skid;
  logic [CTRL_W-1:0] main_ctrl;

  assign beat_in    = {in_data, in_dst, in_fp_dst, in_ctrl};
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);
  assign in_fire    = in_valid & in_ready_q;
  assign out_fire   = main_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d    = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (in_fire) begin
            state_d = TWO;
            ld_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d      = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so it never follows out_ready combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)
        main_q <= beat_in;
      else if (ld_main_skid)
        main_q <= skid_q;
      if (ld_skid)
        skid_q <= beat_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (main_valid && !out_ready && stall_cnt != STALL_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign {out_data, out_dst, out_fp_dst, main_ctrl} = main_q;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_valid = main_valid;
  assign in_ready  = in_ready_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a negedge monitor keeps a scoreboard of accepted
// beats and checks every presented beat, occupancy, in_ready and the stall count.
module tb_pipe_stage_skid;
  localparam int DW = 64;
  localparam int NC = 2;
  localparam int DSTW = 5;
  localparam int CW = 4;
  localparam int SW = 4;
  localparam int SMAX = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [NC*DW-1:0]   in_data, out_data;
  logic [DSTW-1:0]    in_dst, in_fp_dst, out_dst, out_fp_dst;
  logic [CW-1:0]      in_ctrl, out_ctrl;
  logic               flush, out_valid, out_ready;
  logic [1:0]         occupancy;
  logic [SW-1:0]      stall_cnt;

  pipe_stage_skid #(.DATA_W(DW), .NUM_CH(NC), .DST_W(DSTW), .CTRL_W(CW), .STALL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dst(in_dst), .in_fp_dst(in_fp_dst), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dst(out_dst), .out_fp_dst(out_fp_dst), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC*DW-1:0] data;
    logic [DSTW-1:0]  dst;
    logic [DSTW-1:0]  fp;
    logic [CW-1:0]    ctrl;
  } beat_t;

  beat_t q[$];
  int    m_stall = 0;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: inputs change at posedge+1, so values here are what the next edge sees.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_stall = 0;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_occupancy", 128'(occupancy), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
      chk("rst_out_data", 128'(out_data), 128'(0));
      chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    end else begin
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("occupancy", 128'(occupancy), 128'(q.size()));
      chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
      chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      if (q.size() == 0) begin
        chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
      end else begin
        chk("out_data", 128'(out_data), 128'(q[0].data));
        chk("out_dst", 128'(out_dst), 128'(q[0].dst));
        chk("out_fp_dst", 128'(out_fp_dst), 128'(q[0].fp));
        chk("out_ctrl", 128'(out_ctrl), 128'(q[0].ctrl));
        if (!out_ready && m_stall < SMAX) m_stall++;
        if (out_ready) void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back({in_data, in_dst, in_fp_dst, in_ctrl});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] c0, input logic [63:0] c1,
                       input logic [DSTW-1:0] d, input logic [DSTW-1:0] f, input logic [CW-1:0] c);
    in_valid  = v;
    in_data   = {c1, c0};
    in_dst    = d;
    in_fp_dst = f;
    in_ctrl   = c;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 64'h0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    flush = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    idle();
    #1;
    step();
    step();
    rst = 1'b0;

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 64'(i), 64'(9 + i), 5'(i), 5'(16 + i), 4'b0011);
      step();
      chk("stream_out_valid", 128'(out_valid), 128'(1));
      chk("stream_out_data", 128'(out_data), {64'(9 + i), 64'(i)});
    end
    idle();
    repeat (3) step();
    chk("stream_stall", 128'(stall_cnt), 128'(0));

    // back-pressure into the skid register, then release
    do_reset();
    drive(1'b1, 64'hA0, 64'hA1, 5'd10, 5'd20, 4'b0101);
    step();
    drive(1'b1, 64'hB0, 64'hB1, 5'd11, 5'd21, 4'b0110);
    step();
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    chk("bp_occupancy_two", 128'(occupancy), 128'(2));
    drive(1'b1, 64'hC0, 64'hC1, 5'd12, 5'd22, 4'b1001);
    repeat (3) step();
    out_ready = 1'b1;
    for (int k = 0; k < 10 && !in_ready; k++) step();
    chk("bp_in_ready_return", 128'(in_ready), 128'(1));
    step();
    idle();
    repeat (3) step();
    chk("bp_stall", 128'(stall_cnt), 128'(4));

    // flush in ONE with a beat offered
    do_reset();
    drive(1'b1, 64'h11, 64'h12, 5'd1, 5'd2, 4'b0011);
    step();
    drive(1'b1, 64'hDD, 64'hDE, 5'd3, 5'd4, 4'b1111);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush1_out_valid", 128'(out_valid), 128'(0));
    chk("flush1_occupancy", 128'(occupancy), 128'(0));

    // flush in TWO with a beat offered
    drive(1'b1, 64'h21, 64'h22, 5'd5, 5'd6, 4'b0011);
    step();
    drive(1'b1, 64'h31, 64'h32, 5'd7, 5'd8, 4'b0111);
    step();
    drive(1'b1, 64'hEE, 64'hEF, 5'd9, 5'd9, 4'b1111);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush2_out_valid", 128'(out_valid), 128'(0));
    chk("flush2_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("flush2_occupancy", 128'(occupancy), 128'(0));
    chk("flush2_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    repeat (3) step();

    // bubble masking after drain
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 64'h55, 64'h66, 5'd13, 5'd14, 4'b1111);
    step();
    idle();
    chk("bubble_live_ctrl", 128'(out_ctrl), 128'(4'b1111));
    step();
    chk("bubble_out_valid", 128'(out_valid), 128'(0));
    chk("bubble_masked_ctrl", 128'(out_ctrl), 128'(0));

    // asynchronous reset while in TWO
    do_reset();
    drive(1'b1, 64'h71, 64'h72, 5'd15, 5'd16, 4'b0011);
    step();
    drive(1'b1, 64'h81, 64'h82, 5'd17, 5'd18, 4'b0011);
    step();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_out_data", 128'(out_data), 128'(0));
    chk("arst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("arst_occupancy", 128'(occupancy), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(1));
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 64'h91, 64'h92, 5'd19, 5'd20, 4'b0001);
    step();
    idle();
    chk("arst_first_valid", 128'(out_valid), 128'(1));
    chk("arst_first_data", 128'(out_data), {64'h92, 64'h91});
    step();

    // stall counter saturation
    do_reset();
    drive(1'b1, 64'hA5, 64'h5A, 5'd21, 5'd22, 4'b0011);
    step();
    idle();
    repeat (20) step();
    chk("stall_saturate", 128'(stall_cnt), 128'(SMAX));
    out_ready = 1'b1;
    repeat (2) step();
    chk("stall_hold_after", 128'(stall_cnt), 128'(SMAX));

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
